// File: rtl/i2c_slave.sv
// I2C target controller: conditions SCL/SDA, detects START/STOP, matches a 7-bit address and moves bytes.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter behind each synchronizer.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | bus free or not yet addressed, line released
// ADDR      | shifting in 7 address bits + R/W on scl_rise
// ADDR_ACK  | driving ACK for a matched address, then enter WRITE or READ
// WRITE     | shifting in a data byte from the master
// WRITE_ACK | driving ACK for a received data byte, then back to WRITE
// READ      | driving tx bits MSB-first after each scl_fall
// MACK      | sampling master ACK/NACK after a transmitted byte
// IGNORE    | not addressed (or master NACK); wait for START or STOP
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h53
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL_i,
    input  logic       SDA_i,
    output logic       SDA_in_en,
    output logic       SDA_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MACK, IGNORE
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_prev, sda_prev;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_cond, stop_cond;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic [7:0] tx_shift;
    logic       rw, ack_phase, last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], SCL_i};
            sda_sync <= {sda_sync[0], SDA_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_hist, sda_hist;

    // Majority of three samples rejects single-clock pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
            scl_s    <= 1'b1;
            sda_s    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
            scl_s    <= (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) | (scl_hist[1] & scl_hist[2]);
            sda_s    <= (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) | (sda_hist[1] & sda_hist[2]);
        end
    end
`else
    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_rise   = scl_s & ~scl_prev;
    assign scl_fall   = ~scl_s & scl_prev;
    assign sda_rise   = sda_s & ~sda_prev;
    assign sda_fall   = ~sda_s & sda_prev;
    assign start_cond = sda_fall & scl_s;
    assign stop_cond  = sda_rise & scl_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            SDA_in_en <= 1'b1;
            SDA_o     <= 1'b1;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            bit_cnt   <= 3'd0;
            shift_reg <= 7'd0;
            tx_shift  <= 8'd0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            last_bit  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // Bus conditions win over bit-level activity in the same cycle.
            if (stop_cond) begin
                state     <= IDLE;
                SDA_in_en <= 1'b1;
                SDA_o     <= 1'b1;
            end else if (start_cond) begin
                state     <= ADDR;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
                SDA_in_en <= 1'b1;
                SDA_o     <= 1'b1;
            end else begin
                case (state)
                    IDLE, IGNORE: ;
                    ADDR: if (scl_rise) begin
                        shift_reg <= {shift_reg[5:0], sda_s};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rw        <= sda_s;
                            ack_phase <= 1'b0;
                            state     <= (shift_reg == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                        end
                    end
                    ADDR_ACK, WRITE_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            ack_phase <= 1'b1;
                            SDA_in_en <= 1'b0;
                            SDA_o     <= 1'b0;
                        end else begin
                            ack_phase <= 1'b0;
                            last_bit  <= 1'b0;
                            if (rw) begin
                                // First read bit goes out on the edge that ends the ACK.
                                state     <= READ;
                                SDA_in_en <= 1'b0;
                                SDA_o     <= tx_data[7];
                                tx_shift  <= {tx_data[6:0], 1'b0};
                                bit_cnt   <= 3'd1;
                            end else begin
                                state     <= WRITE;
                                SDA_in_en <= 1'b1;
                                SDA_o     <= 1'b1;
                                bit_cnt   <= 3'd0;
                            end
                        end
                    end
                    WRITE: if (scl_rise) begin
                        shift_reg <= {shift_reg[5:0], sda_s};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data   <= {shift_reg, sda_s};
                            rx_valid  <= 1'b1;
                            ack_phase <= 1'b0;
                            state     <= WRITE_ACK;
                        end
                    end
                    READ: if (scl_fall) begin
                        if (last_bit) begin
                            SDA_in_en <= 1'b1;
                            SDA_o     <= 1'b1;
                            state     <= MACK;
                        end else begin
                            SDA_in_en <= 1'b0;
                            SDA_o     <= tx_shift[7];
                            tx_shift  <= {tx_shift[6:0], 1'b0};
                            bit_cnt   <= bit_cnt + 3'd1;
                            last_bit  <= (bit_cnt == 3'd7);
                        end
                    end
                    MACK: if (scl_rise) begin
                        if (!sda_s) begin
                            tx_shift <= tx_data;
                            bit_cnt  <= 3'd0;
                            last_bit <= 1'b0;
                            state    <= READ;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master on a wired-AND SDA bus with hand-computed expectations.
module tb_i2c_slave;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda;
    logic       sda_bus;
    logic       SDA_in_en, SDA_o, rx_valid;
    logic [7:0] rx_data, tx_data;
    int         n_vec = 0;
    int         n_err = 0;
    int         rx_cnt = 0;

    assign sda_bus = m_sda & (SDA_in_en | SDA_o);

    i2c_slave #(.SLAVE_ADDR(7'h53)) dut (
        .clk       (clk),
        .rst       (rst),
        .SCL_i     (m_scl),
        .SDA_i     (sda_bus),
        .SDA_in_en (SDA_in_en),
        .SDA_o     (SDA_o),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rx_valid) rx_cnt <= rx_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    // One SCL period; samples the bus and the slave's enable mid-way through SCL high.
    task automatic clock_bit(input logic b, output logic s, output logic e);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(Q);
        s = sda_bus;
        e = SDA_in_en;
        tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack, output logic ack_en, output logic en_after);
        logic s, e;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s, e);
        clock_bit(1'b1, ack, ack_en);
        en_after = SDA_in_en;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d, output logic en_any, output logic en_after);
        logic s, e;
        d = 8'h00;
        en_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s, e);
            d = {d[6:0], s};
            en_any = en_any | e;
        end
        clock_bit(mack, s, e);
        en_after = SDA_in_en;
    endtask

    initial begin
        logic       ack, ack_en, en_after, en_any, s, e;
        logic [7:0] rd, a6;
        int         base;

        a6 = 8'hA6;
        m_scl = 1'b1; m_sda = 1'b1; tx_data = 8'h96; rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_en",    SDA_in_en, 1);
        check("rst_o",     SDA_o, 1);
        check("rst_rx",    rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);

        // Matching write address, then STOP
        i2c_start();
        send_byte(8'hA6, ack, ack_en, en_after);
        check("addr_ack",     ack, 0);
        check("addr_ack_en",  ack_en, 0);
        check("addr_release", en_after, 1);
        i2c_stop();
        check("stop_en", SDA_in_en, 1);

        // Address mismatch: no ACK, and the rest of the transfer is ignored
        i2c_start();
        send_byte(8'h54, ack, ack_en, en_after);
        check("miss_ack_en", ack_en, 1);
        check("miss_ack",    ack, 1);
        send_byte(8'hA6, ack, ack_en, en_after);
        check("miss_ignore", ack_en, 1);
        i2c_stop();

        // Write one data byte
        i2c_start();
        send_byte(8'hA6, ack, ack_en, en_after);
        base = rx_cnt;
        send_byte(8'h3C, ack, ack_en, en_after);
        check("wr_ack",     ack, 0);
        check("wr_ack_en",  ack_en, 0);
        check("wr_release", en_after, 1);
        check("wr_data",    rx_data, 8'h3C);
        check("wr_pulses",  rx_cnt - base, 1);
        i2c_stop();

        // Read: first byte from load at ACK end, master ACK reloads, master NACK ends
        i2c_start();
        send_byte(8'hA7, ack, ack_en, en_after);
        check("rd_addr_ack", ack, 0);
        tx_data = 8'h5A;
        read_byte(1'b0, rd, en_any, en_after);
        check("rd_byte0",  rd, 8'h96);
        check("rd_drive0", en_any, 0);
        read_byte(1'b1, rd, en_any, en_after);
        check("rd_byte1",   rd, 8'h5A);
        check("rd_release", en_after, 1);
        send_byte(8'hA6, ack, ack_en, en_after);
        check("rd_ignore", ack_en, 1);
        i2c_stop();

        // Repeated START after an address ACK
        i2c_start();
        send_byte(8'hA6, ack, ack_en, en_after);
        i2c_start();
        send_byte(8'hA7, ack, ack_en, en_after);
        check("rs_ack",    ack, 0);
        check("rs_ack_en", ack_en, 0);
        read_byte(1'b1, rd, en_any, en_after);
        check("rs_byte", rd, 8'h5A);
        i2c_stop();

        // STOP in the middle of a data byte
        i2c_start();
        send_byte(8'hA6, ack, ack_en, en_after);
        base = rx_cnt;
        clock_bit(1'b1, s, e);
        clock_bit(1'b0, s, e);
        clock_bit(1'b1, s, e);
        clock_bit(1'b1, s, e);
        i2c_stop();
        check("mid_en",     SDA_in_en, 1);
        check("mid_pulses", rx_cnt - base, 0);
        send_byte(8'hA6, ack, ack_en, en_after);
        check("mid_idle", ack_en, 1);

        // Reset while the slave drives an address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(a6[i], s, e);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q / 2);
        check("pre_rst_drive", SDA_in_en, 0);
        rst = 1'b1;
        tick(1);
        check("rst_ack_en", SDA_in_en, 1);
        rst = 1'b0;
        tick(Q);
        m_scl = 1'b0; tick(Q);
        send_byte(8'hA6, ack, ack_en, en_after);
        check("rst_idle", ack_en, 1);
        i2c_stop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
